uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Shares the single UART transmitter between up to NUM_REQ on-chip requesters. The block sits between the requesters and the UART's Tx_Data / Transmit_Start / Tx_Busy port group. It grants round-robin, latches the winner's byte, and holds Transmit_Start until the transmitter accepts the byte. It then reports acceptance, or a start timeout, back to the winner.

## Interface
- DATA_BITS, 8, width of one UART data byte
- NUM_REQ, 4, number of requesters (2..16, need not be a power of two)
- START_TIMEOUT, 16, Clk cycles Transmit_Start is held waiting for Tx_Busy before giving up (≥2)
- ID_W, $clog2(NUM_REQ), width of Grant_Id

Ports:
- Clk  in  1  baud-rate clock, same clock as the UART transmitter
- Rst  in  1  synchronous, active-low reset
- Req  in  NUM_REQ  requester i has a byte pending
- Req_Data  in  NUM_REQ*DATA_BITS  byte of requester i at [i*DATA_BITS +: DATA_BITS]
- CTS  in  1  remote clear-to-send; no new grant while low
- Tx_Busy  in  1  from the UART transmitter
- Tx_Data  out  DATA_BITS  latched byte to the transmitter
- Transmit_Start  out  1  start request to the transmitter
- Ack  out  NUM_REQ  one-cycle pulse: requester's byte accepted
- Err  out  NUM_REQ  one-cycle pulse: start timed out, byte dropped
- Grant_Id  out  ID_W  index of current/last winner
- Arb_Busy  out  1  high whenever state ≠ IDLE

## Operation
- Reset (Rst=0 at posedge) forces these values: state IDLE, Transmit_Start=0, Tx_Data=0, Ack=0, Err=0, Grant_Id=0, Arb_Busy=0, priority pointer Ptr=0, timeout counter=0. Reset mid-transfer aborts it with no Ack or Err pulse.
- IDLE → START: requires Tx_Busy=0, CTS=1 and |Req. The winner is the first i with Req[i]=1, searching Ptr, Ptr+1, … with wrap at NUM_REQ (explicit wrap; not modulo 2^ID_W). On the transition: latch Tx_Data=Req_Data[winner], set Grant_Id=winner, set Transmit_Start=1, clear the counter.
- START: Transmit_Start stays 1 and the counter increments each cycle.
  - Tx_Busy=1 sampled → Transmit_Start=0, Ack[Grant_Id]=1 for one cycle, go to DRAIN.
  - Counter reaches START_TIMEOUT−1 with Tx_Busy=0 → Transmit_Start=0, Err[Grant_Id]=1 for one cycle, go to IDLE.
  - Tx_Busy=1 and timeout on the same edge → Tx_Busy wins (Ack, DRAIN).
- DRAIN → IDLE: taken when Tx_Busy=0 is sampled.
- Ptr update: on the Ack or Err edge, Ptr = Grant_Id+1, wrapping NUM_REQ−1 → 0.
- Req sampling: Req is sampled only in IDLE.
  - Deasserting Req after the grant does not cancel the transfer; the data is already latched.
  - Requesters hold Req and Req_Data stable until Ack or Err.
  - A requester that keeps Req high after Ack is treated as a new request.
- CTS and Tx_Busy outside the grant:
  - CTS dropping in START or DRAIN has no effect.
  - Tx_Busy=1 while IDLE (e.g. BIST owns the transmitter) blocks all grants.
- Tx_Data persistence: Tx_Data and Grant_Id hold their last value until the next grant.

## Timing
- Req[i] high and the other IDLE conditions true at edge k: Transmit_Start=1 and Arb_Busy=1 after edge k.
- Tx_Busy first sampled high at edge m: Ack pulse is high for the cycle after edge m, and Transmit_Start=0 after edge m.
- Timeout: Transmit_Start is high for exactly START_TIMEOUT cycles, then Err pulses in the cycle immediately following.
- Back-to-back: after Tx_Busy falls, the earliest next Transmit_Start is 2 edges later (DRAIN→IDLE, then IDLE→START).
- Pulse exclusivity: Ack and Err are never high together, and at most one bit of each is high at a time.

## Test plan
- Single requester:
  - Stimulus: Req=4'b0100, Req_Data[2]=8'hA5; model transmitter raises Tx_Busy 2 cycles after Transmit_Start for 12 cycles.
  - Response: Tx_Data=8'hA5, Grant_Id=2, Ack=4'b0100 for one cycle, Ptr=3, Arb_Busy falls 1 cycle after Tx_Busy falls.
- Round-robin:
  - Stimulus: Req=4'b1111 held, data i=8'h10+i.
  - Response: grant order 0,1,2,3,0; each byte appears on Tx_Data in that order; exactly one Ack per grant.
- Start timeout:
  - Stimulus: Req=4'b0001; Tx_Busy held 0.
  - Response: Transmit_Start high for 16 cycles, then Err=4'b0001 for one cycle, no Ack, state IDLE, Ptr=1.
- Blocking conditions:
  - Stimulus: Req=4'b0010 with CTS=0, then with Tx_Busy=1 in IDLE.
  - Response: no Transmit_Start while blocked; grant occurs 1 cycle after CTS=1 and Tx_Busy=0.
- Simultaneous and withdrawn events:
  - Stimulus A: Tx_Busy rises on the timeout edge.
  - Response A: Ack, not Err.
  - Stimulus B: Req dropped in START.
  - Response B: transfer completes with Ack.
- Mid-transfer reset:
  - Stimulus: Rst=0 during DRAIN.
  - Response: next cycle all outputs at reset values, Ptr=0, no Ack/Err pulse.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if
// Groups the requester-side and UART-side signals of the UART transmit arbiter.
//   Req            requester i has a byte pending
//   Req_Data       byte of requester i at [i*DATA_BITS +: DATA_BITS]
//   CTS            remote clear-to-send
//   Tx_Busy        busy flag from the UART transmitter
//   Tx_Data        latched byte presented to the transmitter
//   Transmit_Start start request to the transmitter
//   Ack / Err      one-cycle per-requester accept / timeout pulses
//   Grant_Id       index of the current or last winner
//   Arb_Busy       arbiter not idle
// The slave modport is the arbiter; the master modport drives requests and
// models the transmitter.
interface uart_tx_arbiter_if #(
  parameter int DATA_BITS = 8,
  parameter int NUM_REQ   = 4,
  parameter int ID_W      = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]           Req;
  logic [NUM_REQ*DATA_BITS-1:0] Req_Data;
  logic                         CTS;
  logic                         Tx_Busy;
  logic [DATA_BITS-1:0]         Tx_Data;
  logic                         Transmit_Start;
  logic [NUM_REQ-1:0]           Ack;
  logic [NUM_REQ-1:0]           Err;
  logic [ID_W-1:0]              Grant_Id;
  logic                         Arb_Busy;

  modport slave (
    input  Req, Req_Data, CTS, Tx_Busy,
    output Tx_Data, Transmit_Start, Ack, Err, Grant_Id, Arb_Busy
  );

  modport master (
    output Req, Req_Data, CTS, Tx_Busy,
    input  Tx_Data, Transmit_Start, Ack, Err, Grant_Id, Arb_Busy
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Shares one UART transmitter among NUM_REQ requesters. Grants round-robin
// from a priority pointer, latches the winner's byte, holds Transmit_Start
// until the transmitter raises Tx_Busy (Ack) or START_TIMEOUT cycles pass
// (Err), then waits for Tx_Busy to fall before the next grant.
// Ports:
//   Clk  baud-rate clock shared with the transmitter
//   Rst  synchronous, active-low reset
//   bus  uart_tx_arbiter_if.slave (requests, data, CTS, transmitter handshake,
//        Ack/Err pulses, Grant_Id, Arb_Busy)
module uart_tx_arbiter #(
  parameter int DATA_BITS     = 8,
  parameter int NUM_REQ       = 4,
  parameter int START_TIMEOUT = 16,
  parameter int ID_W          = $clog2(NUM_REQ)
) (
  input  logic                Clk,
  input  logic                Rst,
  uart_tx_arbiter_if.slave    bus
);

  localparam int CNT_W = (START_TIMEOUT > 2) ? $clog2(START_TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [ID_W-1:0]      ptr_q, ptr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DATA_BITS-1:0] tx_data_q, tx_data_d;
  logic [ID_W-1:0]      grant_id_q, grant_id_d;
  logic                 start_q, start_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic [NUM_REQ-1:0]   err_q, err_d;

  logic                 found;
  logic [ID_W-1:0]      win;
  logic [ID_W-1:0]      next_ptr;
  logic [NUM_REQ-1:0]   grant_onehot;

  // Round-robin search starting at ptr_q. The wrap is done against NUM_REQ
  // explicitly so non-power-of-two requester counts never index past the end.
  always_comb begin
    int idx;
    logic [ID_W-1:0] sel;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    sel   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      sel = ID_W'(idx);
      if (!found && bus.Req[sel]) begin
        found = 1'b1;
        win   = sel;
      end
    end
  end

  assign next_ptr     = (grant_id_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;
  assign grant_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id_q;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    tx_data_d  = tx_data_q;
    grant_id_d = grant_id_q;
    start_d    = start_q;
    ack_d      = '0;
    err_d      = '0;
    case (state_q)
      IDLE: begin
        // Tx_Busy high while idle means someone else owns the transmitter.
        if (!bus.Tx_Busy && bus.CTS && found) begin
          state_d    = START;
          tx_data_d  = bus.Req_Data[int'(win)*DATA_BITS +: DATA_BITS];
          grant_id_d = win;
          start_d    = 1'b1;
          cnt_d      = '0;
        end
      end
      START: begin
        // Tx_Busy is checked first so it wins over a coincident timeout.
        if (bus.Tx_Busy) begin
          start_d = 1'b0;
          ack_d   = grant_onehot;
          ptr_d   = next_ptr;
          state_d = DRAIN;
        end else if (cnt_q == CNT_W'(START_TIMEOUT - 1)) begin
          start_d = 1'b0;
          err_d   = grant_onehot;
          ptr_d   = next_ptr;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DRAIN: begin
        if (!bus.Tx_Busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      cnt_q      <= '0;
      tx_data_q  <= '0;
      grant_id_q <= '0;
      start_q    <= 1'b0;
      ack_q      <= '0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      tx_data_q  <= tx_data_d;
      grant_id_q <= grant_id_d;
      start_q    <= start_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
    end
  end

  assign bus.Tx_Data        = tx_data_q;
  assign bus.Transmit_Start = start_q;
  assign bus.Ack            = ack_q;
  assign bus.Err            = err_q;
  assign bus.Grant_Id       = grant_id_q;
  assign bus.Arb_Busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: directed stimulus, expected Ack/Err events
// queued by the stimulus and popped by a separate monitor.
module tb_uart_tx_arbiter;
  localparam int DATA_BITS = 8;
  localparam int NUM_REQ   = 4;
  localparam int TO        = 16;
  localparam int ID_W      = 2;

  logic Clk;
  logic Rst;

  uart_tx_arbiter_if #(.DATA_BITS(DATA_BITS), .NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

  uart_tx_arbiter #(
    .DATA_BITS(DATA_BITS), .NUM_REQ(NUM_REQ), .START_TIMEOUT(TO), .ID_W(ID_W)
  ) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic       is_err;
    int         id;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, req, req);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic push(input logic is_err, input int id, input logic [7:0] data);
    exp_t e;
    e.is_err = is_err;
    e.id     = id;
    e.data   = data;
    exp_q.push_back(e);
  endtask

  task automatic set_data(input int i, input logic [7:0] v);
    bus.Req_Data[i*DATA_BITS +: DATA_BITS] = v;
  endtask

  // Monitor: every Ack/Err pulse must match the oldest queued expectation.
  always @(negedge Clk) begin
    if (bus.Ack != '0 || bus.Err != '0) begin
      exp_t e;
      if (bus.Ack != '0 && bus.Err != '0)
        chk("ack_err_exclusive", 1, 0);
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", {bus.Err, bus.Ack}, 0);
      end else begin
        e = exp_q.pop_front();
        chk("pulse_ack", int'(bus.Ack), e.is_err ? 0 : (1 << e.id));
        chk("pulse_err", int'(bus.Err), e.is_err ? (1 << e.id) : 0);
        chk("pulse_grant_id", int'(bus.Grant_Id), e.id);
        chk("pulse_tx_data", int'(bus.Tx_Data), int'(e.data));
      end
    end
  end

  // Waits (bounded) for Transmit_Start, then models a transmitter that raises
  // Tx_Busy two cycles later for busy_len cycles. Req becomes req_after once
  // the byte is accepted (or right after grant when drop_in_start is set).
  task automatic xfer(input int id, input logic [7:0] data,
                      input logic [3:0] req_after, input bit drop_in_start,
                      input int busy_len);
    int n;
    push(1'b0, id, data);
    n = 0;
    while (!bus.Transmit_Start && n < 20) begin
      tick();
      n++;
    end
    chk("grant_seen", int'(bus.Transmit_Start), 1);
    if (!bus.Transmit_Start) return;
    chk("grant_id", int'(bus.Grant_Id), id);
    chk("grant_tx_data", int'(bus.Tx_Data), int'(data));
    chk("grant_arb_busy", int'(bus.Arb_Busy), 1);
    if (drop_in_start) bus.Req = '0;
    tick();
    tick();
    bus.Tx_Busy = 1'b1;
    tick();
    chk("start_drop_on_busy", int'(bus.Transmit_Start), 0);
    bus.Req = req_after;
    for (int i = 1; i < busy_len; i++) tick();
    chk("drain_arb_busy", int'(bus.Arb_Busy), 1);
    bus.Tx_Busy = 1'b0;
    tick();
    chk("idle_after_drain", int'(bus.Arb_Busy), 0);
  endtask

  task automatic do_reset();
    Rst = 1'b0;
    tick();
    tick();
    Rst = 1'b1;
  endtask

  initial begin
    int n;
    Rst         = 1'b0;
    bus.Req     = '0;
    bus.CTS     = 1'b1;
    bus.Tx_Busy = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) set_data(i, 8'h10 + 8'(i));
    do_reset();

    // Reset values
    chk("rst_start", int'(bus.Transmit_Start), 0);
    chk("rst_tx_data", int'(bus.Tx_Data), 0);
    chk("rst_ack", int'(bus.Ack), 0);
    chk("rst_err", int'(bus.Err), 0);
    chk("rst_grant_id", int'(bus.Grant_Id), 0);
    chk("rst_arb_busy", int'(bus.Arb_Busy), 0);

    // Single requester 2 with 8'hA5, 12-cycle busy
    set_data(2, 8'hA5);
    bus.Req = 4'b0100;
    tick();
    chk("single_start_next_edge", int'(bus.Transmit_Start), 1);
    xfer(2, 8'hA5, 4'b0000, 1'b0, 12);
    chk("single_data_persist", int'(bus.Tx_Data), 8'hA5);
    // Pointer is now 3: requester 3 beats requester 0
    bus.Req = 4'b1001;
    xfer(3, 8'h13, 4'b0000, 1'b0, 3);
    set_data(2, 8'h12);

    // Round-robin from a fresh pointer
    do_reset();
    bus.Req = 4'b1111;
    xfer(0, 8'h10, 4'b1111, 1'b0, 3);
    xfer(1, 8'h11, 4'b1111, 1'b0, 3);
    xfer(2, 8'h12, 4'b1111, 1'b0, 3);
    xfer(3, 8'h13, 4'b1111, 1'b0, 3);
    xfer(0, 8'h10, 4'b0000, 1'b0, 3);
    tick();
    chk("rr_idle", int'(bus.Arb_Busy), 0);

    // Start timeout on requester 0
    bus.Req = 4'b0001;
    push(1'b1, 0, 8'h10);
    tick();
    n = 0;
    while (bus.Transmit_Start && n < 40) begin
      n++;
      tick();
    end
    chk("timeout_start_cycles", n, TO);
    chk("timeout_idle", int'(bus.Arb_Busy), 0);
    chk("timeout_err_now", int'(bus.Err), 1);
    bus.Req = '0;
    // Pointer is now 1
    bus.Req = 4'b0011;
    xfer(1, 8'h11, 4'b0000, 1'b0, 3);

    // Blocking by CTS, then by Tx_Busy while idle
    bus.CTS = 1'b0;
    bus.Req = 4'b0010;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n += int'(bus.Transmit_Start);
    end
    chk("blocked_by_cts", n, 0);
    bus.CTS     = 1'b1;
    bus.Tx_Busy = 1'b1;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n += int'(bus.Transmit_Start);
    end
    chk("blocked_by_busy", n, 0);
    bus.Tx_Busy = 1'b0;
    tick();
    chk("unblocked_grant", int'(bus.Transmit_Start), 1);
    xfer(1, 8'h11, 4'b0000, 1'b0, 3);

    // Tx_Busy rises on the timeout edge: Ack wins
    bus.Req = 4'b0100;
    push(1'b0, 2, 8'h12);
    tick();
    chk("sim_grant", int'(bus.Transmit_Start), 1);
    bus.Req = '0;
    for (int i = 0; i < TO - 1; i++) tick();
    chk("sim_still_start", int'(bus.Transmit_Start), 1);
    bus.Tx_Busy = 1'b1;
    tick();
    chk("sim_start_low", int'(bus.Transmit_Start), 0);
    chk("sim_in_drain", int'(bus.Arb_Busy), 1);
    chk("sim_ack", int'(bus.Ack), 4'b0100);
    bus.Tx_Busy = 1'b0;
    tick();

    // Req withdrawn during START still completes (CTS drop ignored too)
    bus.Req = 4'b1000;
    tick();
    bus.CTS = 1'b0;
    xfer(3, 8'h13, 4'b0000, 1'b1, 3);
    bus.CTS = 1'b1;

    // Reset in DRAIN: Ack for the accepted byte, then nothing
    bus.Req = 4'b0010;
    push(1'b0, 1, 8'h11);
    tick();
    chk("mrst_grant", int'(bus.Grant_Id), 1);
    bus.Req = '0;
    bus.Tx_Busy = 1'b1;
    tick();
    tick();
    chk("mrst_drain", int'(bus.Arb_Busy), 1);
    Rst = 1'b0;
    tick();
    chk("mrst_start", int'(bus.Transmit_Start), 0);
    chk("mrst_tx_data", int'(bus.Tx_Data), 0);
    chk("mrst_grant_id", int'(bus.Grant_Id), 0);
    chk("mrst_arb_busy", int'(bus.Arb_Busy), 0);
    chk("mrst_ack_err", int'({bus.Ack, bus.Err}), 0);
    Rst = 1'b1;
    bus.Tx_Busy = 1'b0;
    tick();
    // Pointer back at 0
    bus.Req = 4'b1111;
    xfer(0, 8'h10, 4'b0000, 1'b0, 3);
    tick();
    tick();

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule
